cmd_uart_wrapper: RTL and testbench

Robot-side endpoint of the BLE/UART command link for the Knight's Tour design.
- Deserialises UART bytes on RX and assembles two consecutive bytes (high byte first) into a 16-bit command for the command processor.
- Serialises a one-byte response (COMM_COMPLETE 8'hA5 / COMM_INTERMEDIATE 8'h5A) back on TX.
- Pairs with the remote-side command sender; sits between the BLE module pins and cmd_proc.

---
 rtl/cmd_uart_wrapper_pkg.sv | 17 +
 rtl/cmd_uart_wrapper_uart_trx.sv | 109 ++++++++++
 rtl/cmd_uart_wrapper.sv | 119 +++++++++++
 tb/tb_cmd_uart_wrapper.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_uart_wrapper_pkg.sv
// Shared types and constants for the BLE/UART command endpoint.
// Build option: CMD_TIMEOUT_EN (see cmd_uart_wrapper) adds a stale-half-command timeout.
package cmd_uart_wrapper_pkg;

  typedef enum logic {
    HIGH = 1'b0,
    LOW  = 1'b1
  } state_t;

  localparam logic [7:0]  COMM_COMPLETE     = 8'hA5;
  localparam logic [7:0]  COMM_INTERMEDIATE = 8'h5A;
  localparam logic [15:0] CALIBRATE         = 16'h0000;

  // 50 MHz / 19200 baud
  localparam int BAUD_DIV_DEFAULT = 2604;

endpackage

// File: rtl/cmd_uart_wrapper_uart_trx.sv
// Full-duplex 8N1 UART: mid-bit sampling receiver plus shift-register transmitter.
// byte_rdy pulses 1 clk after the stop-bit sample; trmt is ignored while a frame is in flight.
module uart_trx
  import cmd_uart_wrapper_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic       TX,
  output logic [7:0] rx_data,
  output logic       byte_rdy,
  input  logic [7:0] tx_data,
  input  logic       trmt,
  output logic       tx_done
);

  localparam logic [11:0] BAUD = 12'(BAUD_DIV);
  localparam logic [11:0] HALF = 12'(BAUD_DIV / 2);

  logic        rx_meta;
  logic        rx_sync;
  logic        rx_prev;
  logic        rx_busy;
  logic [11:0] rx_cnt;
  logic [3:0]  rx_bits;
  logic [9:0]  rx_shift;
  logic        rx_framing_unused;

  logic [9:0]  tx_shift;
  logic        tx_busy;
  logic [11:0] tx_cnt;
  logic [3:0]  tx_bits;

  // Receiver: falling edge on the synchronised line while idle starts a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_busy  <= 1'b0;
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
      byte_rdy <= 1'b0;
    end else begin
      rx_meta  <= RX;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      byte_rdy <= 1'b0;
      if (!rx_busy) begin
        if (rx_prev && !rx_sync) begin
          rx_busy <= 1'b1;
          rx_cnt  <= HALF;
          rx_bits <= '0;
        end
      end else if (rx_cnt == 12'd1) begin
        rx_shift <= {rx_sync, rx_shift[9:1]};
        rx_cnt   <= BAUD;
        if (rx_bits == 4'd9) begin
          rx_busy  <= 1'b0;
          byte_rdy <= 1'b1;
        end else begin
          rx_bits <= rx_bits + 4'd1;
        end
      end else begin
        rx_cnt <= rx_cnt - 12'd1;
      end
    end
  end

  // Start and stop samples are shifted through but never inspected.
  assign rx_data           = rx_shift[8:1];
  assign rx_framing_unused = rx_shift[9] ^ rx_shift[0];

  // Transmitter: idle shift register is all ones so TX rests high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift <= '1;
      tx_busy  <= 1'b0;
      tx_cnt   <= '0;
      tx_bits  <= '0;
      tx_done  <= 1'b0;
    end else if (trmt && !tx_busy) begin
      tx_shift <= {1'b1, tx_data, 1'b0};
      tx_busy  <= 1'b1;
      tx_cnt   <= '0;
      tx_bits  <= '0;
      tx_done  <= 1'b0;
    end else if (tx_busy) begin
      if (tx_cnt == BAUD - 12'd1) begin
        tx_cnt   <= '0;
        tx_shift <= {1'b1, tx_shift[9:1]};
        if (tx_bits == 4'd9) begin
          tx_busy <= 1'b0;
          tx_done <= 1'b1;
        end else begin
          tx_bits <= tx_bits + 4'd1;
        end
      end else begin
        tx_cnt <= tx_cnt + 12'd1;
      end
    end
  end

  assign TX = tx_shift[0];

endmodule

// File: rtl/cmd_uart_wrapper.sv
// Assembles two UART bytes (high first) into a 16-bit command and returns a 1-byte response.
// Build option: CMD_TIMEOUT_EN discards a high byte left waiting longer than TIMEOUT_CYC clks.
module cmd_uart_wrapper
  import cmd_uart_wrapper_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
`ifdef CMD_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 2000000
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        trmt,
  output logic        tx_done
);

  state_t      state;
  state_t      nxt_state;
  logic [7:0]  rx_data;
  logic        byte_rdy;
  logic [7:0]  high_byte;
  logic        latch_high;
  logic        load_cmd;
  logic        drop_high;

  uart_trx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_trx (
    .clk      (clk),
    .rst_n    (rst_n),
    .RX       (RX),
    .TX       (TX),
    .rx_data  (rx_data),
    .byte_rdy (byte_rdy),
    .tx_data  (resp),
    .trmt     (trmt),
    .tx_done  (tx_done)
  );

`ifdef CMD_TIMEOUT_EN
  logic [21:0] to_cnt;
  logic        timed_out;

  assign timed_out = (state == LOW) && (to_cnt == 22'(TIMEOUT_CYC));

  // Counts only while a high byte is waiting; any state change restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state == HIGH || nxt_state != state) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 22'd1;
    end
  end
`else
  logic timed_out;
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HIGH;
    end else begin
      state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state = state;
    case (state)
      HIGH: if (byte_rdy) nxt_state = LOW;
      LOW:  if (byte_rdy || timed_out) nxt_state = HIGH;
      default: nxt_state = HIGH;
    endcase
  end

  always_comb begin
    latch_high = 1'b0;
    load_cmd   = 1'b0;
    drop_high  = 1'b0;
    case (state)
      HIGH: latch_high = byte_rdy;
      LOW: begin
        load_cmd  = byte_rdy;
        drop_high = !byte_rdy && timed_out;
      end
      default: ;
    endcase
  end

  // A completing command beats a simultaneous clear request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_byte <= '0;
      cmd       <= '0;
      cmd_rdy   <= 1'b0;
    end else begin
      if (latch_high) begin
        high_byte <= rx_data;
      end else if (drop_high) begin
        high_byte <= '0;
      end
      if (load_cmd) begin
        cmd     <= {high_byte, rx_data};
        cmd_rdy <= 1'b1;
      end else if (clr_cmd_rdy || latch_high) begin
        cmd_rdy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cmd_uart_wrapper.sv
// Randomised bench for cmd_uart_wrapper: a byte-level scoreboard predicts every command,
// a frame model predicts every TX bit, and literal vectors pin both models.
module tb_cmd_uart_wrapper;
  import cmd_uart_wrapper_pkg::*;

  localparam int BAUD    = 32;
  localparam int TIMEOUT = 300;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RX;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        trmt;
  logic        tx_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [15:0] c;
    int          t;
  } exp_t;

  exp_t        exp_q[$];
  logic        have_high;
  logic [7:0]  high_b;
  logic [15:0] last_cmd;
  logic        rdy_q;
  logic [9:0]  rec;
  logic [9:0]  rec2;
  logic [9:0]  lit;

  cmd_uart_wrapper #(
    .BAUD_DIV    (BAUD)
`ifdef CMD_TIMEOUT_EN
    , .TIMEOUT_CYC (TIMEOUT)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .trmt        (trmt),
    .tx_done     (tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard compare: every rising cmd_rdy must match the oldest predicted command.
  always @(negedge clk) begin
    if (!rst_n) begin
      rdy_q = 1'b0;
    end else begin
      if (cmd_rdy && !rdy_q) begin
        if (exp_q.size() == 0) begin
          check("unexpected_cmd_rdy", 32'(cmd), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          int   d;
          e = exp_q.pop_front();
          d = cyc - e.t;
          check("cmd_value", 32'(cmd), 32'(e.c));
          check("cmd_rdy_latency", 32'(d >= BAUD / 2 && d <= BAUD / 2 + 6), 32'd1);
          last_cmd = e.c;
        end
      end else begin
        check("cmd_hold", 32'(cmd), 32'(last_cmd));
      end
      rdy_q = cmd_rdy;
    end
  end

  // Drives the first nbits of an 8N1 frame; a full frame updates the command model.
  task automatic send_byte(input logic [7:0] b, input int nbits);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int k = 0; k < nbits; k++) begin
      RX = fr[k];
      if (k == 9) begin
        if (have_high) begin
          exp_q.push_back('{c: {high_b, b}, t: cyc});
          have_high = 1'b0;
        end else begin
          high_b    = b;
          have_high = 1'b1;
        end
      end
      repeat (BAUD) @(negedge clk);
    end
  endtask

  task automatic send_cmd(input logic [15:0] c);
    send_byte(c[15:8], 10);
    send_byte(c[7:0], 10);
  endtask

  task automatic wait_rdy(input string nm);
    int k = 0;
    while (!cmd_rdy && k < 4 * BAUD) begin
      @(negedge clk);
      k++;
    end
    check(nm, 32'(cmd_rdy), 32'd1);
  endtask

  // Pulses trmt and checks every clk of the resulting frame against {stop, data, start}.
  task automatic tx_frame(input logic [7:0] b, input bit inject, output logic [9:0] bits);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    bits = '0;
    @(negedge clk);
    resp = b;
    trmt = 1'b1;
    @(negedge clk);
    trmt = 1'b0;
    for (int n = 0; n <= 10 * BAUD; n++) begin
      if (n == 0) check("tx_done_cleared", 32'(tx_done), 32'd0);
      if (n < 10 * BAUD) begin
        check("tx_bit", 32'(TX), 32'(fr[n / BAUD]));
        if (n % BAUD == BAUD / 2) bits[n / BAUD] = TX;
      end
      if (n == 10 * BAUD - 1) check("tx_done_early", 32'(tx_done), 32'd0);
      if (n == 10 * BAUD) begin
        check("tx_done_set", 32'(tx_done), 32'd1);
        check("tx_idle_high", 32'(TX), 32'd1);
      end
      if (inject && n == 4 * BAUD + 3) begin
        resp = ~b;
        trmt = 1'b1;
      end else begin
        trmt = 1'b0;
      end
      if (n < 10 * BAUD) @(negedge clk);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    have_high = 1'b0;
    last_cmd  = '0;
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  initial begin
    int t0;
    rst_n       = 1'b0;
    RX          = 1'b1;
    trmt        = 1'b0;
    resp        = '0;
    clr_cmd_rdy = 1'b0;
    model_reset();
    rdy_q       = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_TX", 32'(TX), 32'd1);
    check("rst_cmd", 32'(cmd), 32'd0);
    check("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    check("rst_tx_done", 32'(tx_done), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    t0 = cyc;
    send_cmd(16'h2ABC);
    wait_rdy("rdy_2ABC");
    check("cmd_2ABC", 32'(cmd), 32'h2ABC);
    check("rdy_2ABC_deadline", 32'(cyc - t0 <= 20 * BAUD), 32'd1);

    send_cmd(CALIBRATE);
    wait_rdy("rdy_cal");
    check("cmd_cal", 32'(cmd), 32'h0000);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    check("clr_rdy", 32'(cmd_rdy), 32'd0);
    check("clr_cmd_kept", 32'(cmd), 32'h0000);

    tx_frame(COMM_COMPLETE, 1'b1, rec);
    lit = 10'b1101001010;
    check("tx_a5_bits", 32'(rec), 32'(lit));
    tx_frame(8'h3C, 1'b0, rec);

    fork
      send_cmd(16'h1234);
      tx_frame(COMM_INTERMEDIATE, 1'b0, rec2);
    join
    wait_rdy("rdy_1234");
    check("cmd_1234", 32'(cmd), 32'h1234);
    lit = 10'b1010110100;
    check("tx_5a_bits", 32'(rec2), 32'(lit));

    send_byte(8'hFF, 10);
    send_byte(8'h43, 4);
    rst_n = 1'b0;
    RX    = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("midrst_cmd", 32'(cmd), 32'd0);
    check("midrst_rdy", 32'(cmd_rdy), 32'd0);
    check("midrst_tx_done", 32'(tx_done), 32'd0);
    rst_n = 1'b1;
    repeat (2 * BAUD) @(negedge clk);
    send_cmd(16'h4321);
    wait_rdy("rdy_4321");
    check("cmd_4321", 32'(cmd), 32'h4321);

`ifdef CMD_TIMEOUT_EN
    send_byte(8'h11, 10);
    repeat (TIMEOUT + 10) @(negedge clk);
    have_high = 1'b0;
    send_cmd(16'h0AB0);
    wait_rdy("rdy_0AB0");
    check("cmd_0AB0", 32'(cmd), 32'h0AB0);
`else
    send_byte(8'h11, 10);
    repeat (TIMEOUT + 10) @(negedge clk);
    send_byte(8'h22, 10);
    wait_rdy("rdy_1122");
    check("cmd_1122", 32'(cmd), 32'h1122);
`endif

    for (int i = 0; i < 25; i++) begin
      logic [15:0] c;
      c = 16'($urandom);
      send_byte(c[15:8], 10);
      repeat ($urandom_range(0, BAUD)) @(negedge clk);
      send_byte(c[7:0], 10);
      wait_rdy("rdy_rand");
      if ($urandom_range(0, 1) == 1) begin
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        check("rand_clr_rdy", 32'(cmd_rdy), 32'd0);
        check("rand_clr_cmd", 32'(cmd), 32'(c));
      end
      repeat ($urandom_range(0, BAUD)) @(negedge clk);
    end

    repeat (BAUD) @(negedge clk);
    check("pending_cmds", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
